// File: rtl/aes_pkg.sv
// Shared types and constants for the AES decryption controller and its output buffer.
package aes_pkg;

    localparam int BLOCK_LENGTH_DEF = 128;
    localparam int NR_AES128        = 10;
    localparam int NR_AES256        = 14;
    localparam int ROUND_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_CAPTURE
    } state_e;

    // A one-cycle key store must be addressed one round ahead of the datapath.
    function automatic logic [ROUND_W-1:0] key_addr_f(
        input logic [ROUND_W-1:0] round,
        input logic               in_round,
        input int                 lat
    );
        if (lat != 0 && in_round && round != '0)
            return round - ROUND_W'(1);
        return round;
    endfunction

endpackage

// File: rtl/aes_out_buf.sv
// One-entry valid/ready register slice holding a finished plaintext block.
module aes_out_buf
    import aes_pkg::*;
#(
    parameter int W = BLOCK_LENGTH_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Refill in the same cycle the held entry drains.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Sequencer for an iterative AES decryption datapath: load, NR+1 rounds, capture into a 1-entry buffer.
// Optional AES_DEC_CTRL_ABORT_EN adds an abort input that drops the in-flight block.
module aes_dec_ctrl
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = BLOCK_LENGTH_DEF,
    parameter int NR           = NR_AES128,
    parameter int KEY_RD_LAT   = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
`ifdef AES_DEC_CTRL_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] in_ct,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLOCK_LENGTH-1:0] out_pt,
    output logic                    dp_en,
    output logic [BLOCK_LENGTH-1:0] dp_ct,
    output logic [ROUND_W-1:0]      dp_round,
    input  logic [BLOCK_LENGTH-1:0] dp_pt,
    output logic [ROUND_W-1:0]      key_addr,
    output logic                    busy
);

    // NR must fit the 4-bit round counter (NR <= 15).
    localparam logic [ROUND_W-1:0] NR_L = ROUND_W'(NR);

    state_e                  state_q, state_d;
    logic [ROUND_W-1:0]      round_q, round_d;
    logic [BLOCK_LENGTH-1:0] ct_q, ct_d;
    logic                    abort_w;
    logic                    buf_valid;
    logic                    buf_ready;

`ifdef AES_DEC_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        ct_d      = ct_q;
        buf_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_LOAD;
                    ct_d    = in_ct;
                    round_d = NR_L;
                end
            end
            ST_LOAD: state_d = ST_ROUND;
            ST_ROUND: begin
                if (round_q == '0) state_d = ST_CAPTURE;
                else               round_d = round_q - ROUND_W'(1);
            end
            ST_CAPTURE: begin
                buf_valid = 1'b1;
                if (buf_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // An aborted block never reaches the buffer.
        if (abort_w && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            round_d   = '0;
            buf_valid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            ct_q    <= ct_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign dp_en    = (state_q == ST_ROUND) || (state_q == ST_CAPTURE);
    assign dp_ct    = ct_q;
    assign dp_round = round_q;
    assign key_addr = key_addr_f(round_q, state_q == ST_ROUND, KEY_RD_LAT);

    aes_out_buf #(
        .W(BLOCK_LENGTH)
    ) u_out_buf (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .in_valid_i (buf_valid),
        .in_ready_o (buf_ready),
        .in_data_i  (dp_pt),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_pt)
    );

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench: two controllers (key latency 0 and 1) each driving an AES-128 inverse-cipher model and key ROM.
`timescale 1ns/1ps
module tb_aes_dec_ctrl;

    localparam int BL = 128;
    localparam int NR = 10;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B = 128'h0123456789abcdeffedcba9876543210;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_ct = '0;
`ifdef AES_DEC_CTRL_ABORT_EN
    logic         abort = 1'b0;
`endif

    logic         in_ready0, out_valid0, dp_en0, busy0;
    logic [127:0] out_pt0, dp_ct0, dp_pt0;
    logic [3:0]   dp_round0, key_addr0;
    logic         in_ready1, out_valid1, dp_en1, busy1;
    logic [127:0] out_pt1, dp_ct1, dp_pt1;
    logic [3:0]   dp_round1, key_addr1;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];
    logic [127:0] pt_b_exp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    aes_dec_ctrl #(.BLOCK_LENGTH(BL), .NR(NR), .KEY_RD_LAT(0)) u_dut0 (
        .CLK(CLK), .RST(RST),
`ifdef AES_DEC_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready0), .in_ct(in_ct),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pt(out_pt0),
        .dp_en(dp_en0), .dp_ct(dp_ct0), .dp_round(dp_round0), .dp_pt(dp_pt0),
        .key_addr(key_addr0), .busy(busy0)
    );

    aes_dec_ctrl #(.BLOCK_LENGTH(BL), .NR(NR), .KEY_RD_LAT(1)) u_dut1 (
        .CLK(CLK), .RST(RST),
`ifdef AES_DEC_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready1), .in_ct(in_ct),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pt(out_pt1),
        .dp_en(dp_en1), .dp_ct(dp_ct1), .dp_round(dp_round1), .dp_pt(dp_pt1),
        .key_addr(key_addr1), .busy(busy1)
    );

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = isbox[gb(s, r + 4*((c - r + 4) % 4))];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c);
            a1 = gb(s, 4*c+1);
            a2 = gb(s, 4*c+2);
            a3 = gb(s, 4*c+3);
            o[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    function automatic logic [127:0] dp_step(input logic [127:0] s, input logic [3:0] rnd,
                                             input logic [127:0] k);
        if (rnd == 4'(NR)) return s ^ k;
        return inv_mix(inv_sr_sb(s) ^ k);
    endfunction

    function automatic logic [127:0] dec_ref(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[NR];
        for (int r = NR - 1; r >= 1; r--) s = inv_mix(inv_sr_sb(s) ^ rk[r]);
        return inv_sr_sb(s) ^ rk[0];
    endfunction

    task automatic build_tables();
        logic [7:0]   inv, a, rc;
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [127:0] k;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            a = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x]  = a;
            isbox[a] = 8'(x);
        end
        k = KEY;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rk[r] = '0;
    endtask

    // ---------------- datapath + key ROM models ----------------
    // The final round writes a separate PT register, so repeated round-0 cycles while stalled are idempotent.
    logic [127:0] st0 = '0, ptr0 = '0;
    logic [127:0] st1 = '0, ptr1 = '0, kq1 = '0;

    always @(posedge CLK) begin
        if (!dp_en0)                st0  <= dp_ct0;
        else if (dp_round0 == 4'd0) ptr0 <= inv_sr_sb(st0) ^ rk[key_addr0];
        else                        st0  <= dp_step(st0, dp_round0, rk[key_addr0]);
    end
    assign dp_pt0 = ptr0;

    always @(posedge CLK) begin
        kq1 <= rk[key_addr1];
        if (!dp_en1)                st1  <= dp_ct1;
        else if (dp_round1 == 4'd0) ptr1 <= inv_sr_sb(st1) ^ kq1;
        else                        st1  <= dp_step(st1, dp_round1, kq1);
    end
    assign dp_pt1 = ptr1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] ct);
        check("send_ready", 128'(in_ready0), 128'(1'b1));
        in_valid = 1'b1;
        in_ct    = ct;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic stable;
        build_tables();
        pt_b_exp = dec_ref(CT_B);
        #1 RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_ctl0", 128'({in_ready0, busy0, dp_en0, out_valid0, dp_round0, key_addr0}), 128'(12'h800));
        check("rst_ctl1", 128'({in_ready1, busy1, dp_en1, out_valid1, dp_round1, key_addr1}), 128'(12'h800));
        check("rst_pt0", out_pt0, '0);
        check("rst_ct0", dp_ct0, '0);
        RST = 1'b1;
        @(negedge CLK);
        check("rel_ready", 128'({in_ready0, in_ready1}), 128'(2'b11));

        // Round trace and latency, buffer free
        out_ready = 1'b1;
        send(CT_A);
        check("load_0", 128'({dp_en0, busy0, in_ready0, dp_ct0 == CT_A}), 128'(4'b0101));
        check("load_ka1", 128'({dp_en1, key_addr1}), 128'({1'b0, 4'(NR)}));
        for (int k = 0; k <= NR; k++) begin
            @(negedge CLK);
            check($sformatf("rnd%0d_0", NR - k), 128'({dp_en0, dp_round0, key_addr0}),
                  128'({1'b1, 4'(NR - k), 4'(NR - k)}));
            check($sformatf("rnd%0d_1", NR - k), 128'({dp_en1, dp_round1, key_addr1}),
                  128'({1'b1, 4'(NR - k), (k == NR) ? 4'd0 : 4'(NR - k - 1)}));
        end
        @(negedge CLK);
        check("cap_0", 128'({dp_en0, dp_round0, key_addr0, busy0, out_valid0}), 128'({1'b1, 8'h00, 2'b10}));
        check("cap_1", 128'({dp_en1, dp_round1, key_addr1, busy1, out_valid1}), 128'({1'b1, 8'h00, 2'b10}));
        @(negedge CLK);
        check("pt_a0", out_pt0, PT_A);
        check("pt_a1", out_pt1, PT_A);
        check("ov_a", 128'({out_valid0, out_valid1, busy0, in_ready0}), 128'(4'b1101));
        @(negedge CLK);
        check("drain_a", 128'({out_valid0, out_valid1}), 128'(2'b00));

        // Backpressure: second block stalls in CAPTURE while the first is held
        out_ready = 1'b0;
        send(CT_A);
        wait_out(lat);
        check("bp_lat", 128'(lat), 128'(NR + 3));
        check("bp_pt_a", out_pt0, PT_A);
        send(CT_B);
        stable = 1'b1;
        repeat (16) begin
            @(negedge CLK);
            if (out_pt0 !== PT_A || out_pt1 !== PT_A || out_valid0 !== 1'b1) stable = 1'b0;
        end
        check("bp_hold_a", 128'(stable), 128'(1'b1));
        check("bp_stall", 128'({busy0, in_ready0, dp_en0, dp_round0}), 128'({3'b101, 4'h0}));
        out_ready = 1'b1;
        @(negedge CLK);
        check("bp_pt_b0", out_pt0, pt_b_exp);
        check("bp_pt_b1", out_pt1, pt_b_exp);
        check("bp_ov_b", 128'({out_valid0, busy0}), 128'(2'b10));
        @(negedge CLK);
        check("bp_drain", 128'(out_valid0), 128'(1'b0));

        // Asynchronous reset in the 5th ROUND cycle
        out_ready = 1'b0;
        send(CT_B);
        wait_out(lat);
        check("rr_buf", out_pt0, pt_b_exp);
        send(CT_A);
        repeat (5) @(negedge CLK);
        check("rr_rnd", 128'(dp_round0), 128'(NR - 4));
        RST = 1'b0;
        #1;
        check("rr_clr0", 128'({busy0, dp_en0, out_valid0, in_ready0, dp_round0}), 128'({4'b0001, 4'h0}));
        check("rr_clr1", 128'({busy1, dp_en1, out_valid1, in_ready1, dp_round1}), 128'({4'b0001, 4'h0}));
        check("rr_pt", out_pt0 | out_pt1 | dp_ct0, '0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rr_ready", 128'({in_ready0, in_ready1, busy0}), 128'(3'b110));
        out_ready = 1'b1;
        send(CT_A);
        wait_out(lat);
        check("rr_lat", 128'(lat), 128'(NR + 3));
        check("rr_pt_a0", out_pt0, PT_A);
        check("rr_pt_a1", out_pt1, PT_A);
        @(negedge CLK);
        check("rr_drain", 128'(out_valid0), 128'(1'b0));

`ifdef AES_DEC_CTRL_ABORT_EN
        // Abort in the 3rd ROUND cycle with a result buffered
        out_ready = 1'b0;
        send(CT_B);
        wait_out(lat);
        check("ab_buf", out_pt0, pt_b_exp);
        send(CT_A);
        repeat (3) @(negedge CLK);
        check("ab_rnd", 128'(dp_round0), 128'(NR - 2));
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("ab_idle", 128'({busy0, in_ready0, dp_en0, busy1}), 128'(4'b0100));
        stable = 1'b1;
        repeat (16) begin
            @(negedge CLK);
            if (out_pt0 !== pt_b_exp || out_valid0 !== 1'b1 || busy0 !== 1'b0) stable = 1'b0;
        end
        check("ab_keep", 128'(stable), 128'(1'b1));
        out_ready = 1'b1;
        @(negedge CLK);
        check("ab_drain", 128'(out_valid0), 128'(1'b0));
        send(CT_A);
        wait_out(lat);
        check("ab_next_pt", out_pt0, PT_A);
        @(negedge CLK);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
